// File: rtl/macguffin_pkg.sv
// rtl/macguffin_pkg.sv - MacGuffin shared constants, S-boxes, F function and FSM states
// Shared by the encryption and decryption datapaths so both sides always use
// identical round logic. No ports.
package macguffin_pkg;

    localparam int WORD_W = 16;
    localparam int RKEY_W = 3 * WORD_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Eight 6-in/2-out S-boxes; entry x of box j sits at SBOX[j][2x+1:2x].
    localparam logic [127:0] SBOX [8] = '{
        128'hE4D12FB8_3A6C5907_0F7E4DA1_C2B65893,
        128'hF18E6B34_97D2A0C5_3D47F28B_C0E91A56,
        128'hA09E63F5_1DC7B428_D7136F0A_B24E8C59,
        128'h7DE3069A_12B8C54F_D8B56F03_47E12AC9,
        128'h2C417AB6_853FD0E9_EB2C47D1_50FA3986,
        128'hC1AF92E8_6D0534B7_9E0A7CD4_32F158B6,
        128'h4B2EF08D_3C975A61_D0B7491A_E35C2F86,
        128'hD8A1F463_0E5B9C27_1FD8A49C_B6E3520F
    };

    // Round function: the three source words are keyed, then box j takes two
    // bits from each keyed word (staggered so every box mixes different bit
    // positions) and produces output bits 2j+1:2j.
    function automatic logic [WORD_W-1:0] f_func(
        input logic [WORD_W-1:0] a,
        input logic [WORD_W-1:0] b,
        input logic [WORD_W-1:0] c,
        input logic [RKEY_W-1:0] k
    );
        logic [WORD_W-1:0] x;
        logic [WORD_W-1:0] y;
        logic [WORD_W-1:0] z;
        logic [WORD_W-1:0] r;
        logic [5:0]        idx;
        x = a ^ k[WORD_W-1:0];
        y = b ^ k[2*WORD_W-1:WORD_W];
        z = c ^ k[3*WORD_W-1:2*WORD_W];
        r = '0;
        for (int j = 0; j < 8; j++) begin
            idx = {x[2*j +: 2], y[(2*j+2)%16 +: 2], z[(2*j+4)%16 +: 2]};
            r[2*j +: 2] = SBOX[j][{idx, 1'b0} +: 2];
        end
        return r;
    endfunction

endpackage

// File: rtl/decryption_if.sv
// rtl/decryption_if.sv - stream bus carrying cipher/plain blocks
// Signals: tdata (block), tvalid (source has data), tready (sink accepts).
// master drives tdata/tvalid, slave drives tready.
interface decryption_if #(
    parameter int W = 4 * macguffin_pkg::WORD_W
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/decr_round.sv
// rtl/decr_round.sv - one combinational MacGuffin decryption round
// Ports: block_i (block before round), key_i (48-bit round key),
//        block_o (block after round).
module decr_round
    import macguffin_pkg::*;
(
    input  logic [4*WORD_W-1:0] block_i,
    input  logic [RKEY_W-1:0]   key_i,
    output logic [4*WORD_W-1:0] block_o
);
    logic [WORD_W-1:0] w0;
    logic [WORD_W-1:0] w1;
    logic [WORD_W-1:0] w2;
    logic [WORD_W-1:0] w3;
    logic [WORD_W-1:0] w3_new;

    assign w0 = block_i[0*WORD_W +: WORD_W];
    assign w1 = block_i[1*WORD_W +: WORD_W];
    assign w2 = block_i[2*WORD_W +: WORD_W];
    assign w3 = block_i[3*WORD_W +: WORD_W];

    // Inverse of the encryption round: undo the XOR into the word that
    // encryption rotated to the top, then rotate it back to position 0.
    assign w3_new  = w3 ^ f_func(w0, w1, w2, key_i);
    assign block_o = {w2, w1, w0, w3_new};
endmodule

// File: rtl/decryption.sv
// rtl/decryption.sv - iterative MacGuffin block decryptor, one round per cycle
// Ports: clk, rst (sync, active-high), round_keys (expanded keys, index 0 =
//        first encryption round), key_ready (keys valid), s_axis (ciphertext
//        in), m_axis (plaintext out). One block in flight at a time.
module decryption
    import macguffin_pkg::*;
#(
    parameter int round_num  = 32,
    parameter int block_size = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [block_size*3/4-1:0] round_keys [round_num],
    input  logic                      key_ready,
    decryption_if.slave               s_axis,
    decryption_if.master              m_axis
);
    localparam int CNT_W = (round_num > 1) ? $clog2(round_num) : 1;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        counter_q, counter_d;
    logic [block_size-1:0]   block_q, block_d;
    logic [block_size-1:0]   round_out;
    logic                    s_ready;
    logic                    m_valid;

    decr_round u_round (
        .block_i (block_q),
        .key_i   (round_keys[counter_q]),
        .block_o (round_out)
    );

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        block_d   = block_q;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                s_ready = key_ready && !rst;
                if (s_ready && s_axis.tvalid) begin
                    block_d   = s_axis.tdata;
                    counter_d = CNT_W'(round_num - 1);
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                block_d = round_out;
                // Counter holds at zero on the last round instead of wrapping.
                if (counter_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    counter_d = counter_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                m_valid = 1'b1;
                if (m_axis.tready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            counter_q <= '0;
            block_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            block_q   <= block_d;
        end
    end

    assign s_axis.tready = s_ready;
    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = block_q;
endmodule

// File: tb/tb_decryption.sv
// tb/tb_decryption.sv - self-checking bench for decryption
module tb_decryption;
    localparam int RN = 32;
    localparam int BS = 64;

    localparam logic [127:0] REF_SBOX [8] = '{
        128'hE4D12FB8_3A6C5907_0F7E4DA1_C2B65893,
        128'hF18E6B34_97D2A0C5_3D47F28B_C0E91A56,
        128'hA09E63F5_1DC7B428_D7136F0A_B24E8C59,
        128'h7DE3069A_12B8C54F_D8B56F03_47E12AC9,
        128'h2C417AB6_853FD0E9_EB2C47D1_50FA3986,
        128'hC1AF92E8_6D0534B7_9E0A7CD4_32F158B6,
        128'h4B2EF08D_3C975A61_D0B7491A_E35C2F86,
        128'hD8A1F463_0E5B9C27_1FD8A49C_B6E3520F
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        key_ready;
    logic [47:0] rk [RN];

    decryption_if #(.W(BS)) s_if ();
    decryption_if #(.W(BS)) m_if ();

    decryption #(.round_num(RN), .block_size(BS)) dut (
        .clk        (clk),
        .rst        (rst),
        .round_keys (rk),
        .key_ready  (key_ready),
        .s_axis     (s_if),
        .m_axis     (m_if)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int dup_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [15:0] ref_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c, input logic [47:0] k);
        int          x, y, z, idx;
        logic [15:0]  r;
        logic [127:0] t;
        x = int'(a ^ k[15:0]);
        y = int'(b ^ k[31:16]);
        z = int'(c ^ k[47:32]);
        r = 16'd0;
        for (int j = 0; j < 8; j++) begin
            idx = ((x >> (2*j)) & 3) * 16 + ((y >> ((2*j+2) % 16)) & 3) * 4
                + ((z >> ((2*j+4) % 16)) & 3);
            t = REF_SBOX[j] >> (2*idx);
            r = r | (16'(t[1:0]) << (2*j));
        end
        return r;
    endfunction

    // Toy key expansion: any 32 keys work for a round trip.
    task automatic set_keys(input logic [127:0] key);
        logic [127:0] t;
        t = key;
        for (int r = 0; r < RN; r++) begin
            t = {t[120:0], t[127:121]} ^ {96'd0, 32'(r) * 32'h9E3779B9};
            rk[r] = t[47:0] ^ t[127:80];
        end
    endtask

    // Forward MacGuffin: w0 ^= F(w1,w2,w3,k[r]) then rotate words down by one.
    function automatic logic [63:0] ref_encrypt(input logic [63:0] pt);
        logic [15:0] w [4];
        logic [15:0] nw;
        for (int i = 0; i < 4; i++) w[i] = pt[16*i +: 16];
        for (int r = 0; r < RN; r++) begin
            nw   = w[0] ^ ref_f(w[1], w[2], w[3], rk[r]);
            w[0] = w[1];
            w[1] = w[2];
            w[2] = w[3];
            w[3] = nw;
        end
        return {w[3], w[2], w[1], w[0]};
    endfunction

    task automatic send(input logic [63:0] ct, input bit rnd, output bit ok);
        ok = 1'b0;
        s_if.tdata  = ct;
        s_if.tvalid = 1'b1;
        for (int n = 0; n < 200 && !ok; n++) begin
            if (rnd) key_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (s_if.tready) ok = 1'b1;
            @(posedge clk); #1;
        end
        s_if.tvalid = 1'b0;
        key_ready   = 1'b1;
    endtask

    task automatic recv(input bit rnd, output logic [63:0] data, output bit ok);
        ok   = 1'b0;
        data = '0;
        for (int n = 0; n < 300 && !ok; n++) begin
            m_if.tready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (rnd) key_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (m_if.tvalid && m_if.tready) begin
                ok   = 1'b1;
                data = m_if.tdata;
            end
            @(posedge clk); #1;
        end
        m_if.tready = 1'b0;
        key_ready   = 1'b1;
    endtask

    task automatic run_block(input logic [63:0] pt, input logic [127:0] key,
                             input logic [63:0] exp, input bit rnd, input string name);
        logic [63:0] ct, got;
        bit          ok;
        set_keys(key);
        ct = ref_encrypt(pt);
        if (rnd) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        send(ct, rnd, ok);
        if (!ok) begin check({name, "_accept_timeout"}, 64'(ok), 64'd1); return; end
        recv(rnd, got, ok);
        if (!ok) begin check({name, "_output_timeout"}, 64'(ok), 64'd1); return; end
        check(name, got, exp);
        @(negedge clk);
        if (m_if.tvalid) dup_bad++;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic [63:0]  pt;
        logic [127:0] key;
        logic [63:0]  exp;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [63:0] ct, ct2, got, d0;
        logic [63:0] p2;
        bit          ok;
        int          first, bad_ready, bad_hold, bad_valid;

        vecs[0] = '{64'h0123456789ABCDEF, 128'h00112233445566778899AABBCCDDEEFF, 64'h0123456789ABCDEF};
        vecs[1] = '{64'h0000000000000000, 128'h0, 64'h0000000000000000};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, {128{1'b1}}, 64'hFFFFFFFFFFFFFFFF};
        vecs[3] = '{64'hAAAA5555AAAA5555, 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0, 64'hAAAA5555AAAA5555};
        vecs[4] = '{64'h8000000000000001, 128'h1, 64'h8000000000000001};

        rst = 1'b1; key_ready = 1'b1;
        s_if.tdata = '0; s_if.tvalid = 1'b1; m_if.tready = 1'b0;
        set_keys(128'h0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("reset_m_tdata", m_if.tdata, 64'd0);
        check("reset_s_tready", 64'(s_if.tready), 64'd0);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 5; i++)
            run_block(vecs[i].pt, vecs[i].key, vecs[i].exp, 1'b0, $sformatf("vector%0d", i));

        // Latency, ready-low window and backpressure.
        set_keys(128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF);
        ct  = ref_encrypt(64'h1122334455667788);
        p2  = 64'h99AABBCCDDEEFF00;
        ct2 = ref_encrypt(p2);
        send(ct, 1'b0, ok);
        check("latency_accept", 64'(ok), 64'd1);
        first = -1; bad_ready = 0;
        for (int k = 0; k <= 40 && first < 0; k++) begin
            @(negedge clk);
            if (m_if.tvalid) first = k;
            if (s_if.tready) bad_ready++;
            if (first < 0) begin @(posedge clk); #1; end
        end
        check("latency_cycles", 64'(first), 64'd32);
        d0 = m_if.tdata;
        check("latency_data", d0, 64'h1122334455667788);
        s_if.tdata = ct2; s_if.tvalid = 1'b1;
        bad_hold = 0;
        repeat (10) begin
            @(posedge clk); @(negedge clk);
            if (m_if.tdata !== d0 || m_if.tvalid !== 1'b1) bad_hold++;
            if (s_if.tready) bad_ready++;
        end
        check("backpressure_hold", 64'(bad_hold), 64'd0);
        check("ready_low_until_m_handshake", 64'(bad_ready), 64'd0);
        @(posedge clk); #1;
        m_if.tready = 1'b1;
        @(posedge clk); #1;
        m_if.tready = 1'b0;
        @(negedge clk);
        check("ready_after_m_handshake", 64'(s_if.tready), 64'd1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        recv(1'b0, got, ok);
        check("pending_block_decrypt", got, p2);

        // Reset in the middle of a block.
        set_keys(128'h13579BDF_2468ACE0_FEDCBA98_76543210);
        send(ref_encrypt(64'h5A5A5A5A5A5A5A5A), 1'b0, ok);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst_s_tready_in_reset", 64'(s_if.tready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_m_tvalid", 64'(m_if.tvalid), 64'd0);
        check("midrst_idle_ready", 64'(s_if.tready), 64'd1);
        check("midrst_block_cleared", m_if.tdata, 64'd0);
        m_if.tready = 1'b1;
        bad_valid = 0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (m_if.tvalid) bad_valid++;
        end
        m_if.tready = 1'b0;
        check("midrst_no_output", 64'(bad_valid), 64'd0);
        @(posedge clk); #1;
        run_block(64'hC3C3A5A5F00F1EE1, 128'h7, 64'hC3C3A5A5F00F1EE1, 1'b0, "after_midrst");

        // key_ready gating.
        set_keys(128'hFEEDFACE_0BADF00D_11111111_22222222);
        key_ready = 1'b0;
        s_if.tdata = ref_encrypt(64'h0F1E2D3C4B5A6978); s_if.tvalid = 1'b1;
        bad_ready = 0;
        repeat (5) begin
            @(negedge clk);
            if (s_if.tready) bad_ready++;
            @(posedge clk); #1;
        end
        check("keyready_low_blocks", 64'(bad_ready), 64'd0);
        key_ready = 1'b1;
        @(negedge clk);
        check("keyready_rise_accept", 64'(s_if.tready), 64'd1);
        @(posedge clk); #1;
        s_if.tvalid = 1'b0;
        recv(1'b0, got, ok);
        check("keyready_decrypt", got, 64'h0F1E2D3C4B5A6978);

        // Random regression.
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] key;
            logic [63:0]  pt;
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom};
            run_block(pt, key, pt, 1'b1, $sformatf("random%0d", i));
        end
        check("no_duplicate_output", 64'(dup_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/decryption.md
DECRYPTION -- requirements
Module: decryption

Interface
REQ-001 Parameter round_num, default 32, number of MacGuffin rounds.
REQ-002 Parameter block_size, default 64, data block width in bits; word width is block_size/4.
REQ-003 Port clk  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port round_keys  input  [block_size*3/4-1:0] x round_num  expanded round keys, index 0 = first encryption round.
REQ-006 Port key_ready  input  1  round_keys valid and stable; no block accepted while low.
REQ-007 Port s_axis_tdata  input  block_size  ciphertext block.
REQ-008 Port s_axis_tvalid  input  1  ciphertext valid.
REQ-009 Port s_axis_tready  output  1  block can be accepted.
REQ-010 Port m_axis_tdata  output  block_size  plaintext block.
REQ-011 Port m_axis_tvalid  output  1  plaintext valid.
REQ-012 Port m_axis_tready  input  1  downstream accepts plaintext.

Function
REQ-013 Word i of a block SHALL be tdata[16*i+15:16*i], matching encryption.
REQ-014 One decryption round with key k SHALL set w3' = w3 ^ F(w0,w1,w2,k), then the new block is (w0..w3) = (w3',w0,w1,w2); F is the package function shared with encryption.
REQ-015 Rounds SHALL use round_keys[round_num-1] first and round_keys[0] last.
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 s_axis_tready SHALL be 1 only in IDLE with key_ready=1 and rst=0.
REQ-018 On an s-handshake, the block register SHALL load s_axis_tdata, the round counter SHALL load round_num-1, and the FSM SHALL go to RUN.
REQ-019 In RUN, each cycle SHALL apply one round with round_keys[counter] and decrement the counter.
REQ-020 When the round with counter=0 completes, the FSM SHALL go to DONE; the counter SHALL never wrap.
REQ-021 m_axis_tvalid SHALL be 1 exactly in DONE; m_axis_tdata SHALL be the block register.
REQ-022 Latency: for an s-handshake at rising edge N, m_axis_tvalid SHALL rise after edge N+round_num.
REQ-023 In DONE, m_axis_tdata and m_axis_tvalid SHALL hold stable until m_axis_tready=1.
REQ-024 The m-handshake SHALL return the FSM to IDLE; s_axis_tready SHALL rise in the following cycle, giving at most one block in flight and a period of round_num+2 cycles.
REQ-025 key_ready falling during RUN or DONE SHALL not affect the block in flight; round_keys stability during RUN is the integrator's obligation.
REQ-026 s_axis_tvalid asserted outside IDLE SHALL be ignored and SHALL not be lost; it stays pending per AXI4-Stream rules.

Reset
REQ-027 While rst=1 at a rising edge: state SHALL be IDLE, counter 0, block register 0, m_axis_tvalid 0, m_axis_tdata 0.
REQ-028 s_axis_tready SHALL be 0 during any cycle in which rst=1.
REQ-029 Reset asserted during RUN or DONE SHALL abort the block; no m_axis_tvalid pulse SHALL follow.

Structure
REQ-030 The shared package macguffin_pkg SHALL hold the S-box tables, the F function, the word width and the FSM state enum; encryption SHALL use the same package.
REQ-031 The combinational round logic SHALL be one sub-module, decr_round, instantiated once; the FSM, counter and block register SHALL live in decryption.

Verification
REQ-032 Round trip: encrypt 64'h0123456789ABCDEF under key 128'h00112233445566778899AABBCCDDEEFF with encryption, feed the ciphertext to decryption -> plaintext equals 64'h0123456789ABCDEF.
REQ-033 Latency: handshake at edge N -> m_axis_tvalid first seen after edge N+32; s_axis_tready stays 0 from N+1 until the m-handshake.
REQ-034 Backpressure: hold m_axis_tready=0 for 10 cycles in DONE -> m_axis_tdata and m_axis_tvalid unchanged, and no new block is accepted.
REQ-035 Mid-operation reset: pulse rst for 1 cycle at round counter 15 -> next cycle state IDLE with m_axis_tvalid=0; a new block then decrypts correctly.
REQ-036 key_ready=0 with s_axis_tvalid=1 -> s_axis_tready stays 0; key_ready rises -> block accepted on that cycle.
REQ-037 Random regression: 1000 random keys and plaintexts with random tvalid/tready gaps -> every decrypted output matches a C reference model, in order, with no loss or duplication.
